// File: rtl/clint_ctrl.sv
// Core-local trap controller: detects ECALL/EBREAK/MRET/async interrupts and sequences CSR writes + redirect.
// Latency: detect in cycle N, trap redirect at N+4, mret redirect at N+2; outputs registered.
// Backpressure: stalls the pipeline via hold_flag_o from detection until the cycle after the redirect strobe.
module clint_ctrl #(
  parameter int INT_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [ADDR_W-1:0] csr_mtvec_i,
  input  logic [ADDR_W-1:0] csr_mepc_i,
  input  logic [31:0]       csr_mstatus_i,
  input  logic              global_int_en_i,
  output logic              hold_flag_o,
  output logic              we_o,
  output logic [31:0]       waddr_o,
  output logic [31:0]       data_o,
  output logic              int_assert_o,
  output logic [ADDR_W-1:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_ASSERT,
    S_W_MSTATUS_MRET,
    S_ASSERT_MRET
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cause_q, cause_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              we_d;
  logic [31:0]       waddr_d;
  logic [31:0]       data_d;
  logic              int_assert_d;
  logic [ADDR_W-1:0] int_addr_d;

  logic        is_ecall, is_ebreak, is_sync, is_mret, is_async, take;
  logic [31:0] mst_trap, mst_mret;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_sync   = is_ecall | is_ebreak;
  assign is_mret   = (inst_i == INST_MRET);
  assign is_async  = (|int_flag_i) & global_int_en_i;
  assign take      = is_sync | is_mret | is_async;

  // Trap entry: MPIE takes MIE, MIE cleared. Return: MIE takes MPIE, MPIE set.
  assign mst_trap = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
  assign mst_mret = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};

  // Stall as soon as a request is seen in IDLE and for the whole sequence.
  assign hold_flag_o = (state_q != S_IDLE) | take;

  // Next state, cause/pc capture and next registered outputs (keyed on the state being entered).
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    pc_d         = pc_q;
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (is_sync) begin
          state_d = S_W_MEPC;
          cause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          pc_d    = inst_addr_i;
        end else if (is_mret) begin
          state_d = S_W_MSTATUS_MRET;
        end else if (is_async) begin
          state_d = S_W_MEPC;
          cause_d = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
          // A jump resolving in execute means inst_addr_i is a squashed slot.
          pc_d    = jump_flag_i ? jump_addr_i : inst_addr_i;
        end
      end
      S_W_MEPC:         state_d = S_W_MSTATUS;
      S_W_MSTATUS:      state_d = S_W_MCAUSE;
      S_W_MCAUSE:       state_d = S_ASSERT;
      S_ASSERT:         state_d = S_IDLE;
      S_W_MSTATUS_MRET: state_d = S_ASSERT_MRET;
      S_ASSERT_MRET:    state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_W_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        data_d  = 32'(pc_d);
      end
      S_W_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = mst_trap;
      end
      S_W_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_q;
      end
      S_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = csr_mtvec_i;
      end
      S_W_MSTATUS_MRET: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = mst_mret;
      end
      S_ASSERT_MRET: begin
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc_i;
      end
      default: ;
    endcase
  end

  // State register plus latched trap cause and return pc.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  // Registered CSR write port and redirect outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      we_o         <= we_d;
      waddr_o      <= waddr_d;
      data_o       <= data_d;
      int_assert_o <= int_assert_d;
      int_addr_o   <= int_addr_d;
    end
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: trap entry, async interrupts, mret, priority, back-to-back and reset abort.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Observed vector = {hold, we, waddr, data, int_assert, int_addr}; waddr/data checked only when we is expected, int_addr only when int_assert is expected.
module tb_clint_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic        clk;
  logic        rstn;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        global_int_en_i;
  logic        hold_flag_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  int nvec = 0;
  int nerr = 0;

  clint_ctrl #(.INT_W(8), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .int_flag_i(int_flag_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .global_int_en_i(global_int_en_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [98:0] pk(input logic h, input logic w, input logic [31:0] a,
                                     input logic [31:0] d, input logic ia, input logic [31:0] ta);
    return {h, w, a, d, ia, ta};
  endfunction

  function automatic logic [98:0] mk(input logic [98:0] e);
    return {2'b11, {64{e[97]}}, 1'b1, {32{e[32]}}};
  endfunction

  task automatic test_reset;
    logic [98:0] obs;
    rstn = 1'b0;
    int_flag_i = '0; inst_i = NOP; inst_addr_i = '0; jump_flag_i = 1'b0; jump_addr_i = '0;
    csr_mtvec_i = '0; csr_mepc_i = '0; csr_mstatus_i = '0; global_int_en_i = 1'b0;
    repeat (2) @(negedge clk);
    obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
    nvec++;
    if (obs !== 99'd0) begin
      nerr++; $display("FAIL reset got=%h want=%h", obs, 99'd0);
    end
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
    nvec++;
    if (obs !== 99'd0) begin
      nerr++; $display("FAIL reset_release got=%h want=%h", obs, 99'd0);
    end
    @(posedge clk); #1;
  endtask

  // ECALL @0x100, mstatus=0x8, mtvec=0x80.
  task automatic test_ecall;
    logic [98:0] e[6];
    logic [98:0] obs;
    e[0] = pk(1, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 32'h341, 32'h100, 0, 0);
    e[2] = pk(1, 1, 32'h300, 32'h80, 0, 0);
    e[3] = pk(1, 1, 32'h342, 32'd11, 0, 0);
    e[4] = pk(1, 0, 0, 0, 1, 32'h80);
    e[5] = pk(0, 0, 0, 0, 0, 0);
    inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h80;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
      nvec++;
      if ((obs & mk(e[i])) !== (e[i] & mk(e[i]))) begin
        nerr++; $display("FAIL ecall cyc%0d got=%h want=%h", i, obs, e[i]);
      end
      @(posedge clk); #1;
      if (i == 0) begin inst_i = NOP; inst_addr_i = 32'h104; end
    end
  endtask

  // Timer interrupt while execute jumps to 0x200: mepc takes the jump target.
  task automatic test_async_jump;
    logic [98:0] e[6];
    logic [98:0] obs;
    e[0] = pk(1, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 32'h341, 32'h200, 0, 0);
    e[2] = pk(1, 1, 32'h300, 32'h80, 0, 0);
    e[3] = pk(1, 1, 32'h342, 32'h8000_0007, 0, 0);
    e[4] = pk(1, 0, 0, 0, 1, 32'h80);
    e[5] = pk(0, 0, 0, 0, 0, 0);
    int_flag_i = 8'h01; global_int_en_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
    inst_addr_i = 32'h108; csr_mstatus_i = 32'h8;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
      nvec++;
      if ((obs & mk(e[i])) !== (e[i] & mk(e[i]))) begin
        nerr++; $display("FAIL async_jump cyc%0d got=%h want=%h", i, obs, e[i]);
      end
      @(posedge clk); #1;
      if (i == 0) begin jump_flag_i = 1'b0; global_int_en_i = 1'b0; end
      if (i == 3) int_flag_i = '0;
    end
  endtask

  // External interrupt masked by MIE=0, then taken once MIE=1.
  task automatic test_async_masked;
    logic [98:0] e[6];
    logic [98:0] obs;
    int_flag_i = 8'h04; global_int_en_i = 1'b0; inst_addr_i = 32'h300; csr_mstatus_i = 32'h8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
      nvec++;
      if ((obs & mk(99'd0)) !== 99'd0) begin
        nerr++; $display("FAIL masked cyc%0d got=%h want=%h", i, obs, 99'd0);
      end
      @(posedge clk); #1;
    end
    e[0] = pk(1, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 32'h341, 32'h300, 0, 0);
    e[2] = pk(1, 1, 32'h300, 32'h80, 0, 0);
    e[3] = pk(1, 1, 32'h342, 32'h8000_000B, 0, 0);
    e[4] = pk(1, 0, 0, 0, 1, 32'h80);
    e[5] = pk(0, 0, 0, 0, 0, 0);
    global_int_en_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
      nvec++;
      if ((obs & mk(e[i])) !== (e[i] & mk(e[i]))) begin
        nerr++; $display("FAIL ext_int cyc%0d got=%h want=%h", i, obs, e[i]);
      end
      @(posedge clk); #1;
      if (i == 0) global_int_en_i = 1'b0;
      if (i == 3) int_flag_i = '0;
    end
  endtask

  // MRET with mstatus=0x80, mepc=0x104.
  task automatic test_mret;
    logic [98:0] e[4];
    logic [98:0] obs;
    e[0] = pk(1, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 32'h300, 32'h88, 0, 0);
    e[2] = pk(1, 0, 0, 0, 1, 32'h104);
    e[3] = pk(0, 0, 0, 0, 0, 0);
    inst_i = MRET; inst_addr_i = 32'h90; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
      nvec++;
      if ((obs & mk(e[i])) !== (e[i] & mk(e[i]))) begin
        nerr++; $display("FAIL mret cyc%0d got=%h want=%h", i, obs, e[i]);
      end
      @(posedge clk); #1;
      if (i == 0) inst_i = NOP;
    end
  endtask

  // ECALL and timer together: sync wins; timer waits for MRET to restore MIE.
  task automatic test_priority;
    logic [98:0] e[14];
    logic [98:0] obs;
    e[0]  = pk(1, 0, 0, 0, 0, 0);
    e[1]  = pk(1, 1, 32'h341, 32'h400, 0, 0);
    e[2]  = pk(1, 1, 32'h300, 32'h80, 0, 0);
    e[3]  = pk(1, 1, 32'h342, 32'd11, 0, 0);
    e[4]  = pk(1, 0, 0, 0, 1, 32'h80);
    e[5]  = pk(0, 0, 0, 0, 0, 0);
    e[6]  = pk(1, 0, 0, 0, 0, 0);
    e[7]  = pk(1, 1, 32'h300, 32'h88, 0, 0);
    e[8]  = pk(1, 0, 0, 0, 1, 32'h404);
    e[9]  = pk(1, 0, 0, 0, 0, 0);
    e[10] = pk(1, 1, 32'h341, 32'h404, 0, 0);
    e[11] = pk(1, 1, 32'h300, 32'h80, 0, 0);
    e[12] = pk(1, 1, 32'h342, 32'h8000_0007, 0, 0);
    e[13] = pk(1, 0, 0, 0, 1, 32'h80);
    inst_i = ECALL; inst_addr_i = 32'h400; int_flag_i = 8'h01; global_int_en_i = 1'b1;
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h80; csr_mepc_i = 32'h404;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
      nvec++;
      if ((obs & mk(e[i])) !== (e[i] & mk(e[i]))) begin
        nerr++; $display("FAIL priority cyc%0d got=%h want=%h", i, obs, e[i]);
      end
      @(posedge clk); #1;
      case (i)
        0: begin inst_i = NOP; global_int_en_i = 1'b0; end
        5: begin inst_i = MRET; csr_mstatus_i = 32'h80; end
        6: inst_i = NOP;
        8: begin global_int_en_i = 1'b1; inst_addr_i = 32'h404; csr_mstatus_i = 32'h8; end
        9: global_int_en_i = 1'b0;
        12: int_flag_i = '0;
        default: ;
      endcase
    end
  endtask

  // EBREAK held in decode: ignored while busy, re-detected the cycle after the redirect.
  task automatic test_back_to_back;
    logic [98:0] e[7];
    logic [98:0] obs;
    e[0] = pk(1, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 32'h341, 32'h500, 0, 0);
    e[2] = pk(1, 1, 32'h300, 32'h80, 0, 0);
    e[3] = pk(1, 1, 32'h342, 32'd3, 0, 0);
    e[4] = pk(1, 0, 0, 0, 1, 32'h80);
    e[5] = pk(1, 0, 0, 0, 0, 0);
    e[6] = pk(1, 1, 32'h341, 32'h500, 0, 0);
    inst_i = EBREAK; inst_addr_i = 32'h500; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h80;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
      nvec++;
      if ((obs & mk(e[i])) !== (e[i] & mk(e[i]))) begin
        nerr++; $display("FAIL back_to_back cyc%0d got=%h want=%h", i, obs, e[i]);
      end
      @(posedge clk); #1;
      if (i == 5) inst_i = NOP;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
    nvec++;
    if ((obs & mk(99'd0)) !== 99'd0) begin
      nerr++; $display("FAIL back_to_back_drain got=%h want=%h", obs, 99'd0);
    end
    @(posedge clk); #1;
  endtask

  // Reset asserted in W_MSTATUS aborts the trap.
  task automatic test_reset_abort;
    logic [98:0] obs;
    inst_i = ECALL; inst_addr_i = 32'h600; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h80;
    @(posedge clk); #1 inst_i = NOP;
    @(posedge clk);
    @(negedge clk);
    obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
    nvec++;
    if (obs !== pk(1, 1, 32'h300, 32'h80, 0, 0)) begin
      nerr++; $display("FAIL abort_pre got=%h want=%h", obs, pk(1, 1, 32'h300, 32'h80, 0, 0));
    end
    #1 rstn = 1'b0;
    #1;
    obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
    nvec++;
    if (obs !== 99'd0) begin
      nerr++; $display("FAIL abort_immediate got=%h want=%h", obs, 99'd0);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
      nvec++;
      if (obs !== 99'd0) begin
        nerr++; $display("FAIL abort_after cyc%0d got=%h want=%h", i, obs, 99'd0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ecall;
    test_async_jump;
    test_async_masked;
    test_mret;
    test_priority;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
